// File: rtl/ps2_key_tracker.sv
// PS/2 Set 2 scan-code decoder tracking eight game keys (held levels, press/release ticks).
// Optional prefix timeout enabled by defining PS2_PREFIX_TIMEOUT_EN.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic [7:0] key_held,
  output logic [7:0] key_press_tick,
  output logic [7:0] key_release_tick,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t     state;
  logic       ext_code;
  logic       key_hit;
  logic [2:0] key_idx;

`ifdef PS2_PREFIX_TIMEOUT_EN
  logic [31:0] timeout_cnt;
`endif

  // Extended keys only match when preceded by E0, so 0x75 alone is treated as unmapped.
  assign ext_code = (state == EXT) || (state == EXT_BRK);

  always_comb begin
    key_hit = 1'b0;
    key_idx = 3'd0;
    if (ext_code) begin
      case (din)
        8'h75: begin key_hit = 1'b1; key_idx = 3'd2; end
        8'h72: begin key_hit = 1'b1; key_idx = 3'd3; end
        default: ;
      endcase
    end else begin
      case (din)
        8'h1D: begin key_hit = 1'b1; key_idx = 3'd0; end
        8'h1B: begin key_hit = 1'b1; key_idx = 3'd1; end
        8'h29: begin key_hit = 1'b1; key_idx = 3'd4; end
        8'h2D: begin key_hit = 1'b1; key_idx = 3'd5; end
        8'h5A: begin key_hit = 1'b1; key_idx = 3'd6; end
        8'h76: begin key_hit = 1'b1; key_idx = 3'd7; end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      key_held         <= 8'h00;
      key_press_tick   <= 8'h00;
      key_release_tick <= 8'h00;
`ifdef PS2_PREFIX_TIMEOUT_EN
      timeout_cnt      <= 32'd0;
`endif
    end else begin
      key_press_tick   <= 8'h00;
      key_release_tick <= 8'h00;
      if (rx_done_tick) begin
`ifdef PS2_PREFIX_TIMEOUT_EN
        timeout_cnt <= 32'd0;
`endif
        case (state)
          IDLE: begin
            if (din == 8'hE0) begin
              state <= EXT;
            end else if (din == 8'hF0) begin
              state <= BRK;
            end else if (din == 8'hAA || din == 8'hFC) begin
              key_held <= 8'h00;
            end else if (key_hit) begin
              key_held[key_idx] <= 1'b1;
              // Typematic repeats of an already-held key produce no press tick.
              if (!key_held[key_idx]) key_press_tick[key_idx] <= 1'b1;
            end
          end
          EXT: begin
            if (din == 8'hF0) begin
              state <= EXT_BRK;
            end else if (din != 8'hE0) begin
              state <= IDLE;
              if (key_hit) begin
                key_held[key_idx] <= 1'b1;
                if (!key_held[key_idx]) key_press_tick[key_idx] <= 1'b1;
              end
            end
          end
          BRK, EXT_BRK: begin
            state <= IDLE;
            if (key_hit) begin
              key_held[key_idx]         <= 1'b0;
              key_release_tick[key_idx] <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_PREFIX_TIMEOUT_EN
      // A stalled prefix is abandoned silently; only busy reflects it.
      else if (state != IDLE) begin
        if (timeout_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          timeout_cnt <= 32'd0;
        end else begin
          timeout_cnt <= timeout_cnt + 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: each byte pushes its expected outputs, compared after the edge.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] key_held;
  logic [7:0] key_press_tick;
  logic [7:0] key_release_tick;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] held;
    logic [7:0] press;
    logic [7:0] rel;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  ps2_key_tracker #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_done_tick     (rx_done_tick),
    .din              (din),
    .key_held         (key_held),
    .key_press_tick   (key_press_tick),
    .key_release_tick (key_release_tick),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
    end
  endtask

  task automatic compareAll(input exp_t e);
    checkOutput({e.tag, ".held"}, key_held, e.held);
    checkOutput({e.tag, ".press"}, key_press_tick, e.press);
    checkOutput({e.tag, ".release"}, key_release_tick, e.rel);
    checkOutput({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
  endtask

  // Called #1 after a posedge; drives one cycle (byte or idle) and checks the result #1 after the next edge.
  task automatic applyStimulus(input string tag, input logic valid, input logic [7:0] b,
                               input logic [7:0] held, input logic [7:0] press,
                               input logic [7:0] rel, input logic bsy);
    exp_t e;
    e.tag = tag; e.held = held; e.press = press; e.rel = rel; e.busy = bsy;
    sb.push_back(e);
    rx_done_tick = valid;
    din = b;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    din = 8'h00;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      compareAll(e);
    end
  endtask

  initial begin
    exp_t z;
    z.tag = "reset"; z.held = 8'h00; z.press = 8'h00; z.rel = 8'h00; z.busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compareAll(z);
    reset = 1'b0;

    // Typematic repeat of W, then release it
    applyStimulus("w_make",     1, 8'h1D, 8'h01, 8'h01, 8'h00, 0);
    applyStimulus("w_gap",      0, 8'h00, 8'h01, 8'h00, 8'h00, 0);
    applyStimulus("w_repeat",   1, 8'h1D, 8'h01, 8'h00, 8'h00, 0);
    applyStimulus("w_f0",       1, 8'hF0, 8'h01, 8'h00, 8'h00, 1);
    applyStimulus("w_break",    1, 8'h1D, 8'h00, 8'h00, 8'h01, 0);

    // Extended Up make then break
    applyStimulus("up_e0",      1, 8'hE0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus("up_make",    1, 8'h75, 8'h04, 8'h04, 8'h00, 0);
    applyStimulus("up_gap",     0, 8'h00, 8'h04, 8'h00, 8'h00, 0);
    applyStimulus("up_e0b",     1, 8'hE0, 8'h04, 8'h00, 8'h00, 1);
    applyStimulus("up_f0",      1, 8'hF0, 8'h04, 8'h00, 8'h00, 1);
    applyStimulus("up_break",   1, 8'h75, 8'h00, 8'h00, 8'h04, 0);
    applyStimulus("up_gap2",    0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Space, R, then BAT pass clears everything
    applyStimulus("space",      1, 8'h29, 8'h10, 8'h10, 8'h00, 0);
    applyStimulus("r_key",      1, 8'h2D, 8'h30, 8'h20, 8'h00, 0);
    applyStimulus("bat_aa",     1, 8'hAA, 8'h00, 8'h00, 8'h00, 0);

    // Mismatched extended code and unmapped break
    applyStimulus("bare_75",    1, 8'h75, 8'h00, 8'h00, 8'h00, 0);
    applyStimulus("unm_f0",     1, 8'hF0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus("unm_3c",     1, 8'h3C, 8'h00, 8'h00, 8'h00, 0);

    // Break of a key never held still ticks
    applyStimulus("esc_f0",     1, 8'hF0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus("esc_break",  1, 8'h76, 8'h00, 8'h00, 8'h80, 0);

    // Repeated E0 stays extended; then Enter; BAT fail clears
    applyStimulus("dn_e0",      1, 8'hE0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus("dn_e0_2",    1, 8'hE0, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus("dn_make",    1, 8'h72, 8'h08, 8'h08, 8'h00, 0);
    applyStimulus("enter",      1, 8'h5A, 8'h48, 8'h40, 8'h00, 0);
    applyStimulus("bat_fc",     1, 8'hFC, 8'h00, 8'h00, 8'h00, 0);

    // Ignored bytes leave S held
    applyStimulus("s_make",     1, 8'h1B, 8'h02, 8'h02, 8'h00, 0);
    applyStimulus("ign_e1",     1, 8'hE1, 8'h02, 8'h00, 8'h00, 0);
    applyStimulus("ign_fa",     1, 8'hFA, 8'h02, 8'h00, 8'h00, 0);
    applyStimulus("ign_fe",     1, 8'hFE, 8'h02, 8'h00, 8'h00, 0);
    applyStimulus("s_f0",       1, 8'hF0, 8'h02, 8'h00, 8'h00, 1);
    applyStimulus("s_break",    1, 8'h1B, 8'h00, 8'h00, 8'h02, 0);

    // Reset mid-prefix discards E0, including a held key
    applyStimulus("rst_pre",    1, 8'h5A, 8'h40, 8'h40, 8'h00, 0);
    applyStimulus("rst_e0",     1, 8'hE0, 8'h40, 8'h00, 8'h00, 1);
    #2 reset = 1'b1;
    #1;
    z.tag = "rst_async";
    compareAll(z);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus("rst_72",     1, 8'h72, 8'h00, 8'h00, 8'h00, 0);

`ifdef PS2_PREFIX_TIMEOUT_EN
    applyStimulus("to_e0",      1, 8'hE0, 8'h00, 8'h00, 8'h00, 1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus($sformatf("to_wait%0d", k), 0, 8'h00, 8'h00, 8'h00, 8'h00, (k < 16));
    end
    applyStimulus("to_72",      1, 8'h72, 8'h00, 8'h00, 8'h00, 0);
`else
    applyStimulus("hold_e0",    1, 8'hE0, 8'h00, 8'h00, 8'h00, 1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus($sformatf("hold_wait%0d", k), 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    end
    applyStimulus("hold_72",    1, 8'h72, 8'h08, 8'h08, 8'h00, 0);
`endif

    checkOutput("sb_drained", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
